// File: rtl/id_grf_pkg.sv
// Shared constants and types for the decode-stage register file.
// Holds register names, sizing defaults and the write-trace record.
package id_grf_pkg;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [4:0] REG_RA    = 5'd31;
    localparam int         GRF_NREG  = 32;
    localparam int         GRF_CNT_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } grf_trace_t;

endpackage

// File: rtl/id_grf_scoreboard.sv
// Pending-write scoreboard: one counter per register 1..NREG-1.
// Ports: issue/retire strobes in, rs/rt busy lookup out, sticky sb_err out.
module grf_scoreboard
    import id_grf_pkg::*;
#(
    parameter int NREG  = GRF_NREG,
    parameter int CNT_W = GRF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_we,
    input  logic [4:0] issue_addr,
    input  logic       ret_we,
    input  logic [4:0] ret_addr,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic             err_q;
    logic             err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 1; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = issue_we && (issue_addr == 5'(r));
            dec = ret_we && (ret_addr == 5'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // A producer retiring this cycle no longer counts: the bypass
    // supplies its value. Compare rather than subtract so a stray
    // retire at count 0 cannot wrap into a false busy.
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic             rs_dec;
    logic             rt_dec;

    always_comb begin
        rs_cnt  = (rs_addr == REG_ZERO) ? '0 : cnt_q[rs_addr];
        rt_cnt  = (rt_addr == REG_ZERO) ? '0 : cnt_q[rt_addr];
        rs_dec  = ret_we && (ret_addr == rs_addr);
        rt_dec  = ret_we && (ret_addr == rt_addr);
        rs_busy = rs_cnt > CNT_W'(rs_dec);
        rt_busy = rt_cnt > CNT_W'(rt_dec);
    end

    assign sb_err = err_q;

endmodule

// File: rtl/id_grf.sv
// Decode-stage GRF: 32x32 registers, $0 = 0, bypassed read ports,
// pending-write scoreboard and a registered writeback trace record.
module id_grf
    import id_grf_pkg::*;
#(
    parameter int NREG  = GRF_NREG,
    parameter int CNT_W = GRF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_we_ID,
    input  logic [4:0]  WB_addr_ID,
    input  logic [31:0] WB_data_ID,
    input  logic [31:0] WB_pc_ID,
    input  logic [4:0]  ID_rs_addr,
    input  logic [4:0]  ID_rt_addr,
    output logic [31:0] ID_rs_data,
    output logic [31:0] ID_rt_data,
    input  logic        ID_issue_we,
    input  logic [4:0]  ID_issue_addr,
    output logic        ID_rs_busy,
    output logic        ID_rt_busy,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic        sb_err
);

    logic [31:0] regs_q [1:NREG-1];
    logic [31:0] regs_d [1:NREG-1];
    logic        wr_hit;

    assign wr_hit = WB_we_ID && (WB_addr_ID != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[WB_addr_ID] = WB_data_ID;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        if (ID_rs_addr == REG_ZERO)
            ID_rs_data = '0;
        else if (WB_we_ID && WB_addr_ID == ID_rs_addr)
            ID_rs_data = WB_data_ID;
        else
            ID_rs_data = regs_q[ID_rs_addr];
    end

    always_comb begin
        if (ID_rt_addr == REG_ZERO)
            ID_rt_data = '0;
        else if (WB_we_ID && WB_addr_ID == ID_rt_addr)
            ID_rt_data = WB_data_ID;
        else
            ID_rt_data = regs_q[ID_rt_addr];
    end

    grf_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_we   (ID_issue_we),
        .issue_addr (ID_issue_addr),
        .ret_we     (WB_we_ID),
        .ret_addr   (WB_addr_ID),
        .rs_addr    (ID_rs_addr),
        .rt_addr    (ID_rt_addr),
        .rs_busy    (ID_rs_busy),
        .rt_busy    (ID_rt_busy),
        .sb_err     (sb_err)
    );

    // Trace logs every WB write, $0 included, so the reference model
    // sees the same retirement stream.
    grf_trace_t trc_q;
    grf_trace_t trc_d;
    logic       tv_q;
    logic       tv_d;

    always_comb begin
        tv_d  = WB_we_ID;
        trc_d = trc_q;
        if (WB_we_ID) trc_d = '{pc: WB_pc_ID, addr: WB_addr_ID, data: WB_data_ID};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv_q  <= 1'b0;
            trc_q <= '0;
        end else begin
            tv_q  <= tv_d;
            trc_q <= trc_d;
        end
    end

    assign trace_valid = tv_q;
    assign trace_pc    = trc_q.pc;
    assign trace_addr  = trc_q.addr;
    assign trace_data  = trc_q.data;

endmodule
